// File: rtl/lcd_timing_driver_if.sv
// Purpose: groups the generator request/response and panel pin signals of the LCD timing driver.
// Latency: none, wiring only.
// Backpressure: none; the panel timing is free-running and the generator must answer on a fixed latency.
interface lcd_timing_driver_if;
    logic        disp_en;
    logic [23:0] pixel_data;
    logic [10:0] pixel_xpos;
    logic [10:0] pixel_ypos;
    logic        lcd_hs;
    logic        lcd_vs;
    logic        lcd_de;
    logic [23:0] lcd_rgb;
    logic        lcd_bl;
    logic        frame_start;

    // Driver side: produces timing and coordinates, consumes enable and pixel data.
    modport master (
        input  disp_en,
        input  pixel_data,
        output pixel_xpos,
        output pixel_ypos,
        output lcd_hs,
        output lcd_vs,
        output lcd_de,
        output lcd_rgb,
        output lcd_bl,
        output frame_start
    );

    // Generator / panel side.
    modport slave (
        output disp_en,
        output pixel_data,
        input  pixel_xpos,
        input  pixel_ypos,
        input  lcd_hs,
        input  lcd_vs,
        input  lcd_de,
        input  lcd_rgb,
        input  lcd_bl,
        input  frame_start
    );
endinterface

// File: rtl/lcd_timing_driver.sv
// Purpose: LCD panel timing generator that requests pixels and re-aligns them with sync/de.
// Latency: counter state to panel pins is PIX_LAT+2 cycles; coordinates leave 1 cycle after the counters.
// Backpressure: none; the generator must return pixel_data exactly PIX_LAT cycles after the coordinates.
module lcd_timing_driver #(
    parameter logic [10:0] H_SYNC  = 11'd41,
    parameter logic [10:0] H_BACK  = 11'd2,
    parameter logic [10:0] H_DISP  = 11'd480,
    parameter logic [10:0] H_FRONT = 11'd2,
    parameter logic [10:0] V_SYNC  = 11'd10,
    parameter logic [10:0] V_BACK  = 11'd2,
    parameter logic [10:0] V_DISP  = 11'd272,
    parameter logic [10:0] V_FRONT = 11'd2,
    parameter int          PIX_LAT = 1
) (
    input  logic                  lcd_pclk,
    input  logic                  sys_rst_n,
    lcd_timing_driver_if.master   bus
);
    // Delay line depth: one stage for the coordinate register, PIX_LAT for the
    // generator, one for the output register.
    localparam int          DLY     = PIX_LAT + 2;
    localparam logic [10:0] H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam logic [10:0] V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam logic [10:0] H_ACT_S = H_SYNC + H_BACK;
    localparam logic [10:0] H_ACT_E = H_ACT_S + H_DISP;
    localparam logic [10:0] V_ACT_S = V_SYNC + V_BACK;
    localparam logic [10:0] V_ACT_E = V_ACT_S + V_DISP;

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [10:0]       h_cnt_q, h_cnt_d;
    logic [10:0]       v_cnt_q, v_cnt_d;
    logic              frame_end;
    logic              hs_n, vs_n, act, fs;
    logic [DLY-1:0]    hs_dly_q, vs_dly_q, act_dly_q, fs_dly_q;
    logic [10:0]       xpos_q, ypos_q;
    logic [23:0]       rgb_q;
    logic              bl_q;

    assign frame_end = (h_cnt_q == H_TOTAL - 11'd1) && (v_cnt_q == V_TOTAL - 11'd1);

    // Next state and counter advance; a stop request only takes effect at the frame end.
    always_comb begin
        state_d = state_q;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        case (state_q)
            IDLE: begin
                h_cnt_d = 11'd0;
                v_cnt_d = 11'd0;
                if (bus.disp_en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (h_cnt_q == H_TOTAL - 11'd1) begin
                    h_cnt_d = 11'd0;
                    v_cnt_d = (v_cnt_q == V_TOTAL - 11'd1) ? 11'd0 : v_cnt_q + 11'd1;
                end else begin
                    h_cnt_d = h_cnt_q + 11'd1;
                end
                if (frame_end && !bus.disp_en) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge lcd_pclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            h_cnt_q <= 11'd0;
            v_cnt_q <= 11'd0;
        end else begin
            state_q <= state_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Stage 0 decode of the counters; IDLE looks like a permanent blanking interval.
    always_comb begin
        hs_n = 1'b1;
        vs_n = 1'b1;
        act  = 1'b0;
        fs   = 1'b0;
        if (state_q == RUN) begin
            hs_n = !(h_cnt_q < H_SYNC);
            vs_n = !(v_cnt_q < V_SYNC);
            act  = (h_cnt_q >= H_ACT_S) && (h_cnt_q < H_ACT_E) &&
                   (v_cnt_q >= V_ACT_S) && (v_cnt_q < V_ACT_E);
            fs   = (h_cnt_q == 11'd0) && (v_cnt_q == 11'd0);
        end
    end

    // Sync/de delay line keeps shifting in IDLE so the last frame drains out intact.
    always_ff @(posedge lcd_pclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hs_dly_q  <= '1;
            vs_dly_q  <= '1;
            act_dly_q <= '0;
            fs_dly_q  <= '0;
        end else begin
            hs_dly_q  <= {hs_dly_q[DLY-2:0], hs_n};
            vs_dly_q  <= {vs_dly_q[DLY-2:0], vs_n};
            act_dly_q <= {act_dly_q[DLY-2:0], act};
            fs_dly_q  <= {fs_dly_q[DLY-2:0], fs};
        end
    end

    // Stage 1 coordinate requests (1-based inside the active window) and backlight.
    always_ff @(posedge lcd_pclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            xpos_q <= 11'd0;
            ypos_q <= 11'd0;
            bl_q   <= 1'b0;
        end else begin
            xpos_q <= act ? h_cnt_q - H_ACT_S + 11'd1 : 11'd0;
            ypos_q <= act ? v_cnt_q - V_ACT_S + 11'd1 : 11'd0;
            bl_q   <= (state_d == RUN);
        end
    end

    // Capture returned pixels in step with de; force black outside the active window.
    always_ff @(posedge lcd_pclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rgb_q <= 24'h0;
        end else begin
            rgb_q <= act_dly_q[DLY-2] ? bus.pixel_data : 24'h0;
        end
    end

    assign bus.pixel_xpos  = xpos_q;
    assign bus.pixel_ypos  = ypos_q;
    assign bus.lcd_hs      = hs_dly_q[DLY-1];
    assign bus.lcd_vs      = vs_dly_q[DLY-1];
    assign bus.lcd_de      = act_dly_q[DLY-1];
    assign bus.frame_start = fs_dly_q[DLY-1];
    assign bus.lcd_rgb     = rgb_q;
    assign bus.lcd_bl      = bl_q;
endmodule

// File: tb/tb_lcd_timing_driver.sv
// Purpose: self-checking bench for lcd_timing_driver at PIX_LAT 1 and 3 against a frame-position model.
// Latency: model predicts pins PIX_LAT+2 cycles and coordinates 1 cycle after the counter position.
// Backpressure: none; stub generators answer on the fixed latency.
module tb_lcd_timing_driver;
    localparam int HS = 2, HB = 2, HD = 8, HF = 2;
    localparam int VS = 1, VB = 1, VD = 4, VF = 1;
    localparam int HT = HS + HB + HD + HF;
    localparam int VT = VS + VB + VD + VF;
    localparam int FRAME = HT * VT;
    localparam int HA = HS + HB;
    localparam int VA = VS + VB;

    logic lcd_pclk = 1'b0;
    logic sys_rst_n = 1'b0;
    logic disp_en = 1'b0;
    logic en;

    always #5 lcd_pclk = ~lcd_pclk;

    lcd_timing_driver_if bus1();
    lcd_timing_driver_if bus3();

    assign bus1.disp_en = disp_en;
    assign bus3.disp_en = disp_en;

    // Stub generators: return {ypos, xpos, 00} after 1 and 3 registers.
    logic [23:0] stub1_q = 24'h0;
    logic [23:0] stub3a_q = 24'h0, stub3b_q = 24'h0, stub3c_q = 24'h0;
    always @(posedge lcd_pclk) begin
        stub1_q  <= {bus1.pixel_ypos[7:0], bus1.pixel_xpos[7:0], 8'h00};
        stub3a_q <= {bus3.pixel_ypos[7:0], bus3.pixel_xpos[7:0], 8'h00};
        stub3b_q <= stub3a_q;
        stub3c_q <= stub3b_q;
    end
    assign bus1.pixel_data = stub1_q;
    assign bus3.pixel_data = stub3c_q;

    lcd_timing_driver #(
        .H_SYNC(11'(HS)), .H_BACK(11'(HB)), .H_DISP(11'(HD)), .H_FRONT(11'(HF)),
        .V_SYNC(11'(VS)), .V_BACK(11'(VB)), .V_DISP(11'(VD)), .V_FRONT(11'(VF)),
        .PIX_LAT(1)
    ) dut1 (
        .lcd_pclk (lcd_pclk),
        .sys_rst_n(sys_rst_n),
        .bus      (bus1)
    );

    lcd_timing_driver #(
        .H_SYNC(11'(HS)), .H_BACK(11'(HB)), .H_DISP(11'(HD)), .H_FRONT(11'(HF)),
        .V_SYNC(11'(VS)), .V_BACK(11'(VB)), .V_DISP(11'(VD)), .V_FRONT(11'(VF)),
        .PIX_LAT(3)
    ) dut3 (
        .lcd_pclk (lcd_pclk),
        .sys_rst_n(sys_rst_n),
        .bus      (bus3)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: history of frame positions, index 0 = position after the next edge.
    bit run_h [6];
    int pos_h [6];

    function automatic bit in_act(input int h, input int v);
        return (h >= HA) && (h < HA + HD) && (v >= VA) && (v < VA + VD);
    endfunction

    // Pins packed as {hs, vs, de, frame_start, bl, rgb, xpos, ypos}.
    function automatic logic [63:0] exp_pins(input int lat);
        int h, v;
        logic hs, vs, de, fs;
        logic [23:0] rgb;
        logic [10:0] xp, yp;
        hs = 1'b1; vs = 1'b1; de = 1'b0; fs = 1'b0; rgb = 24'h0; xp = 11'd0; yp = 11'd0;
        if (run_h[lat + 2]) begin
            h  = pos_h[lat + 2] % HT;
            v  = pos_h[lat + 2] / HT;
            hs = (h >= HS);
            vs = (v >= VS);
            de = in_act(h, v);
            fs = (pos_h[lat + 2] == 0);
            if (de) rgb = {8'(v - VA + 1), 8'(h - HA + 1), 8'h00};
        end
        if (run_h[1]) begin
            h = pos_h[1] % HT;
            v = pos_h[1] / HT;
            if (in_act(h, v)) begin
                xp = 11'(h - HA + 1);
                yp = 11'(v - VA + 1);
            end
        end
        return {13'd0, hs, vs, de, fs, run_h[0], rgb, xp, yp};
    endfunction

    function automatic logic [63:0] obs1();
        return {13'd0, bus1.lcd_hs, bus1.lcd_vs, bus1.lcd_de, bus1.frame_start, bus1.lcd_bl,
                bus1.lcd_rgb, bus1.pixel_xpos, bus1.pixel_ypos};
    endfunction

    function automatic logic [63:0] obs3();
        return {13'd0, bus3.lcd_hs, bus3.lcd_vs, bus3.lcd_de, bus3.frame_start, bus3.lcd_bl,
                bus3.lcd_rgb, bus3.pixel_xpos, bus3.pixel_ypos};
    endfunction

    task automatic model_edge();
        bit nr;
        int np;
        if (!sys_rst_n) begin
            for (int k = 0; k < 6; k++) begin
                run_h[k] = 1'b0;
                pos_h[k] = 0;
            end
        end else begin
            nr = run_h[0];
            np = pos_h[0];
            if (!run_h[0]) begin
                if (disp_en) begin
                    nr = 1'b1;
                    np = 0;
                end
            end else if (pos_h[0] == FRAME - 1 && !disp_en) begin
                nr = 1'b0;
                np = 0;
            end else begin
                np = (pos_h[0] + 1) % FRAME;
            end
            for (int k = 5; k > 0; k--) begin
                run_h[k] = run_h[k - 1];
                pos_h[k] = pos_h[k - 1];
            end
            run_h[0] = nr;
            pos_h[0] = np;
        end
    endtask

    // Per-frame statistics on the PIX_LAT=1 panel pins.
    bit agg_en = 1'b1;
    int fr_len = 0, hs_lo = 0, vs_lo = 0, de_n = 0, fs_seen = 0;

    task automatic agg_update();
        if (bus1.frame_start === 1'b1) begin
            if (agg_en && fs_seen > 0) begin
                check("frame_len", 64'(fr_len), 64'(FRAME));
                check("hs_low_per_frame", 64'(hs_lo), 64'(HS * VT));
                check("vs_low_per_frame", 64'(vs_lo), 64'(VS * HT));
                check("de_per_frame", 64'(de_n), 64'(HD * VD));
            end
            fs_seen++;
            fr_len = 0; hs_lo = 0; vs_lo = 0; de_n = 0;
        end
        fr_len++;
        if (bus1.lcd_hs === 1'b0) hs_lo++;
        if (bus1.lcd_vs === 1'b0) vs_lo++;
        if (bus1.lcd_de === 1'b1) de_n++;
    endtask

    // One clock: compare at the falling edge, then set inputs for the next rising edge.
    task automatic cycle(input logic en_i, input logic rst_n_i);
        bit fell;
        @(negedge lcd_pclk);
        check("pins_lat1", obs1(), exp_pins(1));
        check("pins_lat3", obs3(), exp_pins(3));
        agg_update();
        disp_en = en_i;
        fell = sys_rst_n && !rst_n_i;
        sys_rst_n = rst_n_i;
        if (fell) begin
            #1;
            model_edge();
            check("async_rst_lat1", obs1(), exp_pins(1));
            check("async_rst_lat3", obs3(), exp_pins(3));
        end else begin
            model_edge();
        end
    endtask

    int fs_mark;
    bit found;
    logic [63:0] e;

    initial begin
        disp_en = 1'b1;
        en = 1'b1;
        model_edge();
        // Reset held with the display enabled: everything idle.
        repeat (4) cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        // Free run for three frames plus margin.
        repeat (3 * FRAME + 20) cycle(1'b1, 1'b1);

        // Drop the enable when the counters reach line 3.
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            if (run_h[0] && pos_h[0] == 3 * HT) found = 1'b1;
            else cycle(1'b1, 1'b1);
        end
        check("reach_line3", 64'(found), 64'd1);
        fs_mark = fs_seen;
        repeat (FRAME + 10) cycle(1'b0, 1'b1);
        check("stop_de_cnt", 64'(de_n), 64'(HD * VD));
        check("stop_no_fs", 64'(fs_seen), 64'(fs_mark));
        agg_en = 1'b0;

        // Restart, then hit reset in the middle of an active line.
        repeat (10) cycle(1'b1, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            e = exp_pins(1);
            if (e[48] && e[37:30] == 8'd3) found = 1'b1;
            else cycle(1'b1, 1'b1);
        end
        check("reach_mid_line", 64'(found), 64'd1);
        repeat (3) cycle(1'b1, 1'b0);
        repeat (FRAME + 20) cycle(1'b1, 1'b1);

        // Randomized enable toggling and reset pulses.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 149) == 0) en = !en;
            if ($urandom_range(0, 399) == 0) begin
                repeat ($urandom_range(1, 3)) cycle(en, 1'b0);
            end
            cycle(en, 1'b1);
        end
        repeat (2 * FRAME) cycle(1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/lcd_timing_driver.md
Name: lcd_timing_driver

Overview:
- Drives the LCD panel timing and consumes pixels from the character/pixel generator on the same lcd_pclk.
- Generates the horizontal and vertical counters, sync and data-enable signals, and backlight control.
- Issues pixel_xpos/pixel_ypos requests to the generator, whose pixel_data returns after a fixed register latency.
- Re-aligns the returned pixel_data with the delayed sync/de pipeline and drives the panel RGB bus.

Parameters:
H_SYNC, 11'd41, hsync pulse width in pclk
H_BACK, 11'd2, horizontal back porch
H_DISP, 11'd480, active pixels per line
H_FRONT, 11'd2, horizontal front porch
V_SYNC, 11'd10, vsync width in lines
V_BACK, 11'd2, vertical back porch
V_DISP, 11'd272, active lines
V_FRONT, 11'd2, vertical front porch
PIX_LAT, 1, generator latency from pixel_xpos/ypos to pixel_data, in cycles (legal 1..3)
- Derived: H_TOTAL = sum of the four H_* values. V_TOTAL = sum of the four V_* values.

Ports:
lcd_pclk  in  1  pixel clock, the only clock
sys_rst_n  in  1  reset, asynchronous assert, active-low
disp_en  in  1  display enable level
pixel_data  in  24  RGB888 from generator, valid PIX_LAT cycles after the coordinates
pixel_xpos  out  11  requested column, 1..H_DISP, 0 outside the active region
pixel_ypos  out  11  requested row, 1..V_DISP, 0 outside the active region
lcd_hs  out  1  hsync, active-low
lcd_vs  out  1  vsync, active-low
lcd_de  out  1  data enable, active-high
lcd_rgb  out  24  panel pixel bus
lcd_bl  out  1  backlight enable
frame_start  out  1  one-cycle pulse aligned with the first lcd_hs-low cycle of the frame

Behaviour:
- One clock; reset is asynchronous and active-low (lcd_pclk, sys_rst_n).
- All outputs are registered.
- Reset values:
  - lcd_hs = 1, lcd_vs = 1
  - lcd_de = 0, lcd_rgb = 0, lcd_bl = 0, frame_start = 0
  - pixel_xpos = 0, pixel_ypos = 0
  - Counters = 0, FSM = IDLE, all delay stages cleared.
- FSM:
  - IDLE: counters held at 0; no requests; hs/vs high; bl = 0.
  - IDLE -> RUN on the edge where disp_en = 1. Counting starts from h = 0, v = 0 on the next edge.
  - RUN: h_cnt increments from 0 to H_TOTAL-1, then wraps to 0 and increments v_cnt.
  - v_cnt wraps from V_TOTAL-1 to 0.
  - RUN -> IDLE only at the frame end (h = H_TOTAL-1, v = V_TOTAL-1) when disp_en = 0 at that edge. A mid-frame deassert completes the current frame.
  - disp_en re-asserted before the frame end cancels the stop.
  - lcd_bl = 1 while in RUN.
- Stage 0 (counters), evaluated in RUN:
  - hs_n = !(h_cnt < H_SYNC)
  - vs_n = !(v_cnt < V_SYNC)
  - act = (H_SYNC+H_BACK <= h_cnt < H_SYNC+H_BACK+H_DISP) AND (V_SYNC+V_BACK <= v_cnt < V_SYNC+V_BACK+V_DISP)
  - fs = (h_cnt == 0 AND v_cnt == 0)
- Stage 1:
  - pixel_xpos = act ? h_cnt - (H_SYNC+H_BACK) + 1 : 0
  - pixel_ypos = act ? v_cnt - (V_SYNC+V_BACK) + 1 : 0
  - Arithmetic is 11-bit unsigned; all counts fit, so no overflow occurs.
- hs_n, vs_n, act and fs pass through a delay line of depth PIX_LAT+2 and emerge as lcd_hs, lcd_vs, lcd_de and frame_start.
- lcd_rgb is registered as lcd_de_next ? pixel_data : 24'h0. Black is forced outside the active window.
- Total latency from counter state to panel pins = PIX_LAT+2 cycles. Pixel and de alignment is exact for any legal PIX_LAT.
- On the RUN -> IDLE transition the delay line drains normally: the last frame's trailing front-porch cycles still exit. No truncation occurs.
- Reset mid-frame clears everything immediately, including the pipeline. The next frame starts only via IDLE -> RUN.

Test Plan:
Use sim params H = 2/2/8/2 (H_TOTAL = 14), V = 1/1/4/1 (V_TOTAL = 7), PIX_LAT = 1. The stub generator registers {ypos[7:0], xpos[7:0], 8'h00}.
1. Reset asserted with disp_en = 1 -> hs = vs = 1, de = 0, rgb = 0, bl = 0 for the whole reset. After release: bl = 1 one cycle later, frame_start pulses 3 cycles after the first counting edge, simultaneous with the first lcd_hs low.
2. Free run for 3 frames -> lcd_hs low exactly 2 of every 14 cycles. lcd_vs low exactly 14 consecutive cycles of every 98. frame_start period = 98.
3. Active window -> lcd_de high 8 consecutive cycles per line on lines 1..4 only (32 per frame). First line rgb = 010100, 010200, ..., 010800. Fourth line starts 040100. rgb = 0 whenever de = 0.
4. disp_en dropped mid-frame (v_cnt = 3) -> frame completes with all 32 de cycles. FSM returns to IDLE at the frame end. hs/vs stay high after the pipeline drains, no further frame_start, bl = 0.
5. sys_rst_n pulsed low mid-line during de = 1 -> de, rgb, xpos, ypos go to 0 asynchronously in the same cycle. After release, timing restarts from frame_start as in scenario 1.
6. PIX_LAT = 3 with the stub delayed accordingly -> identical rgb/de pattern to scenario 3, with all panel outputs shifted 2 cycles later.
